xbus_arbiter: RTL

//  Two-master arbiter in front of xaddr_decoder: shares the single addr/sel/we/data bus between
//  the CPU (m0) and the external/debug master (m1). Round-robin grant, one transaction at a time,

---
 rtl/xbus_arbiter_pkg.sv | 25 ++
 rtl/xbus_arbiter_rr_pick.sv | 15 +
 rtl/xbus_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/xbus_arbiter_pkg.sv
// Shared widths, FSM encodings and the round-robin pick rule for the two-master bus arbiter.
package xbus_arbiter_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Single requester wins outright; when both request, the one not served last wins.
    function automatic logic rr_winner(input logic [1:0] req, input logic last_grant);
        logic win;
        if (req == 2'b11) begin
            win = ~last_grant;
        end else begin
            win = req[1];
        end
        return win;
    endfunction

endpackage

// File: rtl/xbus_arbiter_rr_pick.sv
// Combinational 2-way round-robin selector used by the bus arbiter in IDLE.
module xarb_rr_pick
    import xbus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);

    // Winner index; meaningless when no request is pending (caller ignores it then).
    always_comb begin
        winner = rr_winner(req, last_grant);
    end

endmodule

// File: rtl/xbus_arbiter.sv
// Two-master arbiter sharing one addr/sel/we/data bus: round-robin grant, one transaction
// at a time, fixed read latency RD_LAT, single-cycle ack with read data to the winner.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | bus free; pick a requester and latch its command
// ARB_ACCESS | bus_sel high for RD_LAT cycles, rdata sampled on the last
// ARB_RESP   | ack pulse to the granted master, grant history updated
module xbus_arbiter
    import xbus_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              bus_sel,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_grant;
    logic              w_grant_nxt;
    logic              r_last_grant;
    logic              w_last_grant_nxt;
    logic              r_bus_sel;
    logic              w_bus_sel_nxt;
    logic              r_bus_we;
    logic              w_bus_we_nxt;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [ADDR_W-1:0] w_bus_addr_nxt;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] w_bus_wdata_nxt;
    logic              r_m0_ack;
    logic              w_m0_ack_nxt;
    logic              r_m1_ack;
    logic              w_m1_ack_nxt;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] w_m0_rdata_nxt;
    logic [DATA_W-1:0] r_m1_rdata;
    logic [DATA_W-1:0] w_m1_rdata_nxt;
    logic [1:0]        w_req;
    logic              w_winner;

    assign w_req = {m1_req, m0_req};

    xarb_rr_pick u_pick (
        .req        (w_req),
        .last_grant (r_last_grant),
        .winner     (w_winner)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:   if (|w_req) w_state_nxt = ARB_ACCESS;
            ARB_ACCESS: if (r_cnt == '0) w_state_nxt = ARB_RESP;
            ARB_RESP:   w_state_nxt = ARB_IDLE;
            default:    w_state_nxt = ARB_IDLE;
        endcase
    end

    // Next values of the registered outputs, counter and grant bookkeeping.
    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_bus_sel_nxt    = r_bus_sel;
        w_bus_we_nxt     = r_bus_we;
        w_bus_addr_nxt   = r_bus_addr;
        w_bus_wdata_nxt  = r_bus_wdata;
        w_m0_ack_nxt     = 1'b0;
        w_m1_ack_nxt     = 1'b0;
        w_m0_rdata_nxt   = r_m0_rdata;
        w_m1_rdata_nxt   = r_m1_rdata;
        case (r_state)
            ARB_IDLE: begin
                if (|w_req) begin
                    w_grant_nxt   = w_winner;
                    w_bus_sel_nxt = 1'b1;
                    w_cnt_nxt     = CNT_LOAD;
                    if (w_winner) begin
                        w_bus_we_nxt    = m1_we;
                        w_bus_addr_nxt  = m1_addr;
                        w_bus_wdata_nxt = m1_wdata;
                    end else begin
                        w_bus_we_nxt    = m0_we;
                        w_bus_addr_nxt  = m0_addr;
                        w_bus_wdata_nxt = m0_wdata;
                    end
                end
            end
            ARB_ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    // Last bus cycle: capture read data and release the bus together,
                    // so bus_we can never outlive bus_sel.
                    w_bus_sel_nxt = 1'b0;
                    w_bus_we_nxt  = 1'b0;
                    if (r_grant) begin
                        w_m1_ack_nxt   = 1'b1;
                        w_m1_rdata_nxt = bus_rdata;
                    end else begin
                        w_m0_ack_nxt   = 1'b1;
                        w_m0_rdata_nxt = bus_rdata;
                    end
                end
            end
            ARB_RESP: begin
                w_last_grant_nxt = r_grant;
            end
            default: begin
                w_bus_sel_nxt = 1'b0;
                w_bus_we_nxt  = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; last_grant resets to 1 so m0 wins the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_bus_sel    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_bus_sel    <= w_bus_sel_nxt;
            r_bus_we     <= w_bus_we_nxt;
            r_bus_addr   <= w_bus_addr_nxt;
            r_bus_wdata  <= w_bus_wdata_nxt;
            r_m0_ack     <= w_m0_ack_nxt;
            r_m1_ack     <= w_m1_ack_nxt;
            r_m0_rdata   <= w_m0_rdata_nxt;
            r_m1_rdata   <= w_m1_rdata_nxt;
        end
    end

    assign bus_sel   = r_bus_sel;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

endmodule
